// File: rtl/dmem_sramlike_bridge.sv
// Bridges the M-stage data access of an in-order pipeline onto an sram-like bus.
// One transaction in flight at a time; the pipeline stalls until the bus reports data_ok.
module dmem_sramlike_bridge (
  input  logic        clk,
  input  logic        resetn,
  // pipeline side
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        longest_stall,
  // sram-like bus side
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no transaction
    ST_REQ  = 2'd1,  // request raised, waiting for addr_ok
    ST_DATA = 2'd2,  // accepted, waiting for data_ok
    ST_DONE = 2'd3   // result captured, held while the pipeline is frozen
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        issue;
  logic        data_done;
  logic        new_wr;
  logic [1:0]  new_size;
  logic [31:0] new_addr;

  assign issue     = (state_q == ST_IDLE) && cpu_en;
  assign data_done = (state_q == ST_DATA) && bus_data_ok;

  // Request fields decoded straight from the pipeline inputs for the issuing cycle.
  always_comb begin
    new_wr   = (cpu_wen != 4'b0000);
    new_addr = new_wr ? cpu_addr : {cpu_addr[31:2], 2'b00};
    unique case (cpu_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: new_size = 2'd0;
      4'b0011, 4'b1100:                   new_size = 2'd1;
      default:                            new_size = 2'd2;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fields are latched only when the request is first raised, so they stay put through REQ.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (issue) begin
      wr_q    <= new_wr;
      size_q  <= new_size;
      addr_q  <= new_addr;
      wdata_q <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'd0;
    end else if (data_done && !wr_q) begin
      rdata_q <= bus_rdata;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_en) begin
          state_d = bus_addr_ok ? ST_DATA : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_addr_ok) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus_data_ok) begin
          state_d = longest_stall ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!longest_stall) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: req/stall are gated by resetn because IDLE & cpu_en is combinational and would
  // otherwise leak a request while reset is still asserted.
  always_comb begin
    bus_req   = resetn && (issue || (state_q == ST_REQ));
    cpu_stall = resetn && (issue || (state_q == ST_REQ) ||
                           ((state_q == ST_DATA) && !bus_data_ok));
    if (state_q == ST_IDLE) begin
      bus_wr    = new_wr;
      bus_size  = new_size;
      bus_addr  = new_addr;
      bus_wdata = cpu_wdata;
    end else begin
      bus_wr    = wr_q;
      bus_size  = size_q;
      bus_addr  = addr_q;
      bus_wdata = wdata_q;
    end
    cpu_rdata = data_done ? bus_rdata : rdata_q;
  end

endmodule

// File: tb/tb_dmem_sramlike_bridge.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_dmem_sramlike_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        longest_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  dmem_sramlike_bridge dut (
    .clk           (clk),
    .resetn        (resetn),
    .cpu_en        (cpu_en),
    .cpu_wen       (cpu_wen),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .longest_stall (longest_stall),
    .bus_req       (bus_req),
    .bus_wr        (bus_wr),
    .bus_size      (bus_size),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_addr_ok   (bus_addr_ok),
    .bus_data_ok   (bus_data_ok)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
    end
  endtask

  // Size from the number of enabled lanes: one lane = byte, an aligned lane pair = half,
  // everything else (including loads) = word.
  function automatic logic [1:0] size_ref(input logic [3:0] wen);
    if ($countones(wen) == 1) return 2'd0;
    if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  // Reference model: where the single transaction is in its life, plus what was latched.
  bit          m_pending;   // raised, not yet accepted
  bit          m_inflight;  // accepted, result not yet returned
  bit          m_holding;   // result returned while the pipeline was frozen
  bit          m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  function automatic bit m_idle();
    return !m_pending && !m_inflight && !m_holding;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pending  <= 1'b0;
      m_inflight <= 1'b0;
      m_holding  <= 1'b0;
      m_wr       <= 1'b0;
      m_size     <= 2'd0;
      m_addr     <= 32'd0;
      m_wdata    <= 32'd0;
      m_rdata    <= 32'd0;
    end else if (m_idle() && cpu_en) begin
      m_wr       <= (cpu_wen != 4'b0000);
      m_size     <= size_ref(cpu_wen);
      m_addr     <= (cpu_wen != 4'b0000) ? cpu_addr : (cpu_addr & 32'hFFFF_FFFC);
      m_wdata    <= cpu_wdata;
      m_pending  <= !bus_addr_ok;
      m_inflight <= bus_addr_ok;
    end else if (m_pending && bus_addr_ok) begin
      m_pending  <= 1'b0;
      m_inflight <= 1'b1;
    end else if (m_inflight && bus_data_ok) begin
      m_inflight <= 1'b0;
      m_holding  <= longest_stall;
      if (!m_wr) m_rdata <= bus_rdata;
    end else if (m_holding && !longest_stall) begin
      m_holding <= 1'b0;
    end
  end

  // Compare process: inputs change 1 time unit after posedge, so the negedge sees settled outputs.
  always @(negedge clk) begin : compare
    bit          e_req;
    bit          e_stall;
    logic [31:0] e_rdata;
    e_req   = resetn && ((m_idle() && cpu_en) || m_pending);
    e_stall = resetn && ((m_idle() && cpu_en) || m_pending || (m_inflight && !bus_data_ok));
    e_rdata = (m_inflight && bus_data_ok) ? bus_rdata : m_rdata;
    check("model_req",   32'(bus_req),   32'(e_req));
    check("model_stall", 32'(cpu_stall), 32'(e_stall));
    check("model_rdata", cpu_rdata,      e_rdata);
    if (e_req && m_idle()) begin
      check("model_wr",    32'(bus_wr),   32'(cpu_wen != 4'b0000));
      check("model_size",  32'(bus_size), 32'(size_ref(cpu_wen)));
      check("model_addr",  bus_addr,
            (cpu_wen != 4'b0000) ? cpu_addr : (cpu_addr & 32'hFFFF_FFFC));
      check("model_wdata", bus_wdata,     cpu_wdata);
    end else if (e_req) begin
      check("model_wr_held",    32'(bus_wr),   32'(m_wr));
      check("model_size_held",  32'(bus_size), 32'(m_size));
      check("model_addr_held",  bus_addr,      m_addr);
      check("model_wdata_held", bus_wdata,     m_wdata);
    end
  end

  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic aok, input logic dok,
                       input logic [31:0] rd, input logic ls);
    @(posedge clk);
    #1;
    cpu_en        = en;
    cpu_wen       = wen;
    cpu_addr      = addr;
    cpu_wdata     = wdata;
    bus_addr_ok   = aok;
    bus_data_ok   = dok;
    bus_rdata     = rd;
    longest_stall = ls;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [3:0] wen_pool [10];

  initial begin
    wen_pool = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001,
                 4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b0111};
    resetn = 1'b0;
    cpu_en = 1'b0; cpu_wen = 4'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0; longest_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    @(negedge clk);
    check("reset_req",   32'(bus_req),   32'h0);
    check("reset_stall", 32'(cpu_stall), 32'h0);
    check("reset_rdata", cpu_rdata,      32'h0);

    // Best-case word load: addr_ok immediately, data_ok the next cycle.
    drive(1'b1, 4'b0000, 32'h1000_0006, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("lw_req",   32'(bus_req),   32'h1);
    check("lw_addr",  bus_addr,       32'h1000_0004);
    check("lw_size",  32'(bus_size),  32'h2);
    check("lw_wr",    32'(bus_wr),    32'h0);
    check("lw_stall", 32'(cpu_stall), 32'h1);
    drive(1'b1, 4'b0000, 32'h1000_0006, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("lw_done_stall", 32'(cpu_stall), 32'h0);
    check("lw_done_req",   32'(bus_req),   32'h0);
    check("lw_rdata",      cpu_rdata,      32'hDEAD_BEEF);
    idle_cycle();
    @(negedge clk);
    check("lw_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);

    // Byte store with addr_ok delayed: request held 4 cycles with frozen fields.
    drive(1'b1, 4'b0100, 32'h0000_0012, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("sb_req",   32'(bus_req),  32'h1);
    check("sb_size",  32'(bus_size), 32'h0);
    check("sb_addr",  bus_addr,      32'h0000_0012);
    check("sb_wr",    32'(bus_wr),   32'h1);
    check("sb_wdata", bus_wdata,     32'h5A5A_5A5A);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b1111, 32'hFFFF_0000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      check("sb_hold_req",   32'(bus_req),   32'h1);
      check("sb_hold_stall", 32'(cpu_stall), 32'h1);
      check("sb_hold_addr",  bus_addr,       32'h0000_0012);
      check("sb_hold_size",  32'(bus_size),  32'h0);
      check("sb_hold_wdata", bus_wdata,      32'h5A5A_5A5A);
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("sb_req_4th", 32'(bus_req), 32'h1);
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
    @(negedge clk);
    check("sb_done_stall", 32'(cpu_stall), 32'h0);
    check("sb_done_rdata", cpu_rdata,      32'h1111_1111);
    idle_cycle();
    @(negedge clk);
    check("sb_keeps_rdata_q", cpu_rdata, 32'hDEAD_BEEF);

    // Result held while the pipeline is frozen; no new request despite cpu_en.
    drive(1'b1, 4'b0000, 32'h0000_0020, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 4'b0000, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
    @(negedge clk);
    check("held_first_rdata", cpu_rdata, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, 32'h0000_0024, 32'h0, 1'b1, 1'b1, 32'h0BAD_BAD0, 1'b1);
      @(negedge clk);
      check("held_req",   32'(bus_req),   32'h0);
      check("held_stall", 32'(cpu_stall), 32'h0);
      check("held_rdata", cpu_rdata,      32'hCAFE_F00D);
    end
    drive(1'b1, 4'b0000, 32'h0000_0024, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("held_release_req", 32'(bus_req), 32'h0);
    drive(1'b1, 4'b0000, 32'h0000_0028, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("after_held_req",  32'(bus_req), 32'h1);
    check("after_held_addr", bus_addr,      32'h0000_0028);
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7777_7777, 1'b0);
    idle_cycle();

    // Reset in DATA, then a spurious data_ok after release.
    drive(1'b1, 4'b0000, 32'h0000_0030, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 4'b0000, 32'h0000_0030, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("data_wait_stall", 32'(cpu_stall), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_req",   32'(bus_req),   32'h0);
    check("async_rst_stall", 32'(cpu_stall), 32'h0);
    check("async_rst_rdata", cpu_rdata,      32'h0);
    @(posedge clk);
    #1;
    resetn      = 1'b1;
    cpu_en      = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h0000_0099;
    @(negedge clk);
    check("spurious_dok_stall", 32'(cpu_stall), 32'h0);
    check("spurious_dok_rdata", cpu_rdata,      32'h0);
    idle_cycle();
    @(negedge clk);
    check("spurious_dok_ignored", cpu_rdata, 32'h0);

    // Half store whose address input changes while the request waits.
    drive(1'b1, 4'b1100, 32'h0000_0040, 32'hABCD_1234, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("sh_req",  32'(bus_req),  32'h1);
    check("sh_size", 32'(bus_size), 32'h1);
    check("sh_addr", bus_addr,      32'h0000_0040);
    drive(1'b1, 4'b0001, 32'h0000_0080, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("sh_hold_addr",  bus_addr,      32'h0000_0040);
    check("sh_hold_size",  32'(bus_size), 32'h1);
    check("sh_hold_wdata", bus_wdata,     32'hABCD_1234);
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    idle_cycle();

    // Randomized soak, checked every cycle by the compare process against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(3, 0) != 0), wen_pool[$urandom_range(9, 0)], $urandom, $urandom,
            $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom,
            $urandom_range(3, 0) == 0);
    end
    repeat (4) idle_cycle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
